// File: rtl/project_pwm_peripheral_capture_pkg.sv
// Shared definitions for the PWM input-capture unit.
// Provides the 2-bit FSM state encoding and the counter saturation value helper.
package project_pwm_peripheral_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } state_t;

    // All-ones value for a counter of the given width; callers cast to their width.
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/project_pwm_peripheral_sync_edge.sv
// Pin-facing front end: SYNC_STAGES-flop synchronizer, one history flop and edge decode.
// Ports:
//   clk    - clock, all logic on posedge
//   reset  - synchronous active-high reset, clears synchronizer and history
//   pin    - asynchronous input
//   level  - synchronized pin value (flop output)
//   rise_c - combinational, synchronized level went 0->1
//   fall_c - combinational, synchronized level went 1->0
module project_pwm_peripheral_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain plus history flop; same latency for both edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~hist_q;
    assign fall_c = ~level & hist_q;

endmodule

// File: rtl/project_pwm_peripheral_capture.sv
// PWM input capture: measures period (rise to rise) and high time in clock cycles,
// presents results through a valid/ack handshake and flags stuck inputs by timeout.
// Ports:
//   i_clk, i_reset - clock and synchronous active-high reset
//   i_enable       - 1 = capture active, 0 = return to idle (results retained)
//   i_pwm          - asynchronous PWM input
//   i_ack          - consumer acknowledge, clears o_valid and o_overrun
//   o_period       - last measured period
//   o_high         - last measured high time
//   o_valid        - result unread
//   o_overrun      - sticky, an unread result was overwritten
//   o_timeout      - one-cycle pulse, no edge within 2^WIDTH-1 cycles
//   o_level        - synchronized pin level, registered
module project_pwm_peripheral_capture
    import project_pwm_peripheral_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_pwm,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_timeout,
    output logic             o_level
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_max(WIDTH));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] period_d, high_out_d;
    logic             valid_d, overrun_d, timeout_d;
    logic             load;
    logic             level, rise, fall;

    project_pwm_peripheral_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (i_clk),
        .reset  (i_reset),
        .pin    (i_pwm),
        .level  (level),
        .rise_c (rise),
        .fall_c (fall)
    );

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WIDTH'(1);

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            high_q    <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            o_timeout <= 1'b0;
            o_level   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            o_period  <= period_d;
            o_high    <= high_out_d;
            o_valid   <= valid_d;
            o_overrun <= overrun_d;
            o_timeout <= timeout_d;
            o_level   <= level;
        end
    end

    // Next-state, measurement and handshake logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_d     = high_q;
        period_d   = o_period;
        high_out_d = o_high;
        valid_d    = o_valid;
        overrun_d  = o_overrun;
        timeout_d  = 1'b0;
        load       = 1'b0;

        if (!i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end
                ST_WAIT_RISE: begin
                    // Partial first period is discarded; only a rise starts measuring.
                    cnt_d = '0;
                    if (rise) begin
                        state_d = ST_MEAS_HIGH;
                        cnt_d   = WIDTH'(1);
                    end
                end
                ST_MEAS_HIGH: begin
                    if (fall) begin
                        high_d  = cnt_q;
                        state_d = ST_MEAS_LOW;
                        cnt_d   = cnt_inc;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WAIT_RISE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_MEAS_LOW: begin
                    // Rise closes one period and immediately opens the next.
                    if (rise) begin
                        load       = 1'b1;
                        period_d   = cnt_q;
                        high_out_d = high_q;
                        state_d    = ST_MEAS_HIGH;
                        cnt_d      = WIDTH'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WAIT_RISE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A coincident ack consumes the old result, so the new one is not an overrun.
        if (load) begin
            valid_d = 1'b1;
            if (i_ack) begin
                overrun_d = 1'b0;
            end else if (o_valid) begin
                overrun_d = 1'b1;
            end
        end else if (i_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_project_pwm_peripheral_capture.sv
// Directed self-checking bench for the PWM capture unit (WIDTH=8, SYNC_STAGES=2).
module tb_project_pwm_peripheral_capture;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             pwm;
    logic             ack;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
    logic             valid;
    logic             overrun;
    logic             timeout;
    logic             level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    project_pwm_peripheral_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_enable  (enable),
        .i_pwm     (pwm),
        .i_ack     (ack),
        .o_period  (period),
        .o_high    (high),
        .o_valid   (valid),
        .o_overrun (overrun),
        .o_timeout (timeout),
        .o_level   (level)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_pwm(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            pwm = 1'b1;
            tick(h);
            pwm = 1'b0;
            tick(l);
        end
    endtask

    task automatic resync();
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        int first_i;
        int pulses;
        logic lvl_at;

        reset  = 1'b1;
        enable = 1'b0;
        pwm    = 1'b0;
        ack    = 1'b0;
        tick(3);
        check("rst_period",  32'(period),  32'd0);
        check("rst_high",    32'(high),    32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_level",   32'(level),   32'd0);
        reset = 1'b0;

        // Test 1: H=3/L=5, three rises -> two results of 8/3, second overwrites first.
        enable = 1'b1;
        tick(3);
        run_pwm(3, 5, 3);
        tick(5);
        check("t1_valid",   32'(valid),   32'd1);
        check("t1_period",  32'(period),  32'd8);
        check("t1_high",    32'(high),    32'd3);
        check("t1_overrun", 32'(overrun), 32'd1);
        check("t1_timeout", 32'(timeout), 32'd0);
        ack_pulse();
        check("t1_ack_valid",   32'(valid),   32'd0);
        check("t1_ack_overrun", 32'(overrun), 32'd0);

        // Test 2: toggle every cycle -> period 2, high 1.
        resync();
        run_pwm(1, 1, 4);
        tick(5);
        check("t2_valid",   32'(valid),   32'd1);
        check("t2_period",  32'(period),  32'd2);
        check("t2_high",    32'(high),    32'd1);
        check("t2_overrun", 32'(overrun), 32'd1);
        ack_pulse();

        // Test 3: unacked results overrun; ack variants.
        resync();
        run_pwm(2, 6, 1);
        run_pwm(4, 4, 1);
        pwm = 1'b1;
        tick(1);
        pwm = 1'b0;
        tick(5);
        check("t3_valid",   32'(valid),   32'd1);
        check("t3_period",  32'(period),  32'd8);
        check("t3_high",    32'(high),    32'd4);
        check("t3_overrun", 32'(overrun), 32'd1);
        ack_pulse();
        check("t3_ack_valid",   32'(valid),   32'd0);
        check("t3_ack_overrun", 32'(overrun), 32'd0);
        pwm = 1'b1;
        tick(3);
        pwm = 1'b0;
        tick(3);
        check("t3_r1_valid",   32'(valid),   32'd1);
        check("t3_r1_overrun", 32'(overrun), 32'd0);
        pwm = 1'b1;
        tick(2);
        ack = 1'b1;          // lands on the edge that loads the H=3/L=3 result
        tick(1);
        ack = 1'b0;
        tick(3);
        check("t3_coinc_valid",   32'(valid),   32'd1);
        check("t3_coinc_overrun", 32'(overrun), 32'd0);
        check("t3_coinc_period",  32'(period),  32'd6);
        check("t3_coinc_high",    32'(high),    32'd3);

        // Test 4: stuck high -> single timeout 258 cycles after the pin rises.
        pwm = 1'b0;
        ack_pulse();
        resync();
        tick(2);
        pwm     = 1'b1;
        first_i = -1;
        pulses  = 0;
        lvl_at  = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            if (timeout) begin
                pulses++;
                if (first_i < 0) begin
                    first_i = i;
                    lvl_at  = level;
                end
            end
        end
        check("t4_pulses",  32'(pulses),  32'd1);
        check("t4_cycle",   32'(first_i), 32'd258);
        check("t4_level",   32'(lvl_at),  32'd1);
        check("t4_period",  32'(period),  32'd6);
        check("t4_high",    32'(high),    32'd3);
        check("t4_valid",   32'(valid),   32'd0);
        pwm = 1'b0;
        tick(3);
        run_pwm(2, 3, 2);
        tick(5);
        check("t4_after_valid",  32'(valid),  32'd1);
        check("t4_after_period", 32'(period), 32'd5);
        check("t4_after_high",   32'(high),   32'd2);

        // Test 5: disable mid MEAS_LOW; first result needs two fresh rises.
        ack_pulse();
        check("t5_ack_valid", 32'(valid), 32'd0);
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(1);
        run_pwm(2, 2, 1);
        tick(5);
        check("t5_one_rise_valid", 32'(valid), 32'd0);
        run_pwm(3, 4, 1);
        tick(5);
        check("t5_valid",   32'(valid),   32'd1);
        check("t5_period",  32'(period),  32'd9);
        check("t5_high",    32'(high),    32'd2);
        check("t5_overrun", 32'(overrun), 32'd0);

        // Test 6: reset in MEAS_HIGH with a pending result.
        pwm = 1'b1;
        tick(5);
        check("t6_pre_valid", 32'(valid), 32'd1);
        reset = 1'b1;
        tick(1);
        check("t6_period",  32'(period),  32'd0);
        check("t6_high",    32'(high),    32'd0);
        check("t6_valid",   32'(valid),   32'd0);
        check("t6_overrun", 32'(overrun), 32'd0);
        check("t6_timeout", 32'(timeout), 32'd0);
        check("t6_level",   32'(level),   32'd0);
        reset = 1'b0;
        tick(3);
        pwm = 1'b0;
        tick(20);
        check("t6_post_valid",  32'(valid),  32'd0);
        check("t6_post_period", 32'(period), 32'd0);
        check("t6_post_high",   32'(high),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/project_pwm_peripheral_capture.md
Name: project_pwm_peripheral_capture

Overview:
PWM input-capture unit; the receive-side counterpart of the peripheral's PWM generator.
- Samples an asynchronous PWM pin and measures period (rising edge to rising edge) and high time in i_clk cycles.
- Presents each completed measurement with a valid/ack handshake.
- Flags stuck-level (0%/100% duty) inputs via a timeout.
- Sits beside the generator in the peripheral; used for loopback checking and for reading external PWM sources.

Parameters:
WIDTH, 16, width of counter and of period/high results
SYNC_STAGES, 2, synchronizer flop count on i_pwm (legal values ≥2)

Ports:
i_clk  input  1  single clock, all logic on posedge
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  1 = capture active; 0 = return to IDLE
i_pwm  input  1  asynchronous PWM input
i_ack  input  1  consumer acknowledge; clears o_valid and o_overrun
o_period  output  WIDTH  last measured period in cycles
o_high  output  WIDTH  last measured high time in cycles
o_valid  output  1  level; result unread
o_overrun  output  1  sticky; a result was overwritten while unread
o_timeout  output  1  one-cycle pulse; no edge within 2^WIDTH-1 cycles
o_level  output  1  synchronized i_pwm, registered

Behaviour:
- Reset (synchronous, i_reset=1 at posedge):
  - State=IDLE; counter=0.
  - o_period=0, o_high=0, o_valid=0, o_overrun=0, o_timeout=0, o_level=0.
  - Synchronizer flops and edge-detect history are cleared to 0.
  - Reset asserted mid-measurement discards the partial result.
- Front end:
  - SYNC_STAGES-flop synchronizer, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Pin-to-detect latency is SYNC_STAGES+1 cycles; identical for both edges, so measured widths are exact.
- Counter r_cnt (WIDTH bits):
  - Loaded with 1 on a rise cycle; otherwise increments.
  - Saturates at 2^WIDTH-1 (never wraps).
  - Example: pin high for H cycles and low for L cycles gives r_cnt=H at the fall cycle and r_cnt=H+L at the next rise cycle.
- States:
  - IDLE: counter held at 0. i_enable=1 -> WAIT_RISE.
  - WAIT_RISE: ignores everything except rise. On rise -> MEAS_HIGH, r_cnt<=1. The first partial period is never reported.
  - MEAS_HIGH: on fall -> capture r_high<=r_cnt, go to MEAS_LOW.
  - MEAS_LOW: on rise -> o_period<=r_cnt, o_high<=r_high, set o_valid, r_cnt<=1, go to MEAS_HIGH (back-to-back measurements, no dead cycle).
  - Any state with i_enable=0 -> IDLE next cycle, counter cleared. Result registers, o_valid and o_overrun are retained.
- Timeout:
  - Triggered in MEAS_HIGH or MEAS_LOW when r_cnt==2^WIDTH-1 and no edge occurs that cycle.
  - Response: o_timeout=1 for one cycle, go to WAIT_RISE, results untouched.
  - An edge in the same cycle takes priority over the timeout.
  - o_level shows the stuck level.
- Handshake:
  - New result with o_valid=0: o_valid<=1.
  - New result with o_valid=1 and i_ack=0: data overwritten, o_overrun<=1.
  - New result and i_ack=1 in the same cycle: data loaded, o_valid stays 1, no overrun.
  - i_ack with no new result: o_valid<=0, o_overrun<=0.
- Minimum resolvable high or low width is 1 cycle. Shorter pulses may be missed; this is not an error.

Decomposition:
- Shared package:
  - State encoding (IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW) as a 2-bit localparam set.
  - Saturation max expression for WIDTH.
- Sub-module project_pwm_peripheral_sync_edge:
  - Contains the synchronizer, history flop and rise/fall/level outputs.
  - Parameterized by SYNC_STAGES.
  - Reused by any future pin-facing input.

Test Plan:
1. Enable, drive i_pwm H=3/L=5 repeating -> after second rising edge o_valid=1, o_period=8, o_high=3; values repeat every 8 cycles.
2. H=1/L=1 (i_pwm toggles every cycle) -> o_period=2, o_high=1 on every measurement.
3. Leave o_valid unacked across two results (H=2/L=6 then H=4/L=4) -> o_period=8, o_high=4, o_overrun=1. i_ack on a cycle with no new result clears both; i_ack coincident with a new result loads data, keeps o_valid=1, leaves o_overrun=0.
4. WIDTH=8, rise then hold i_pwm high -> exactly one o_timeout pulse when the count reaches 255, o_level=1, state WAIT_RISE; o_period and o_high unchanged.
5. Drop i_enable mid MEAS_LOW, then re-enable -> no result reported from the partial period; first new result arrives only after two further rises.
6. Assert i_reset during MEAS_HIGH with o_valid=1 -> next cycle all outputs are 0; no stale result appears after release.
